// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the dual-read MAC FIFO controller.
package fifo_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } ctrl_state_t;

  // Width of the optional request-stall counter.
  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/fifo_ctrl_occ.sv
// Up/down occupancy counter for one FIFO read head.
// Inc and Dec together leave the count unchanged. Callers guarantee that the
// count never goes past its range.
module fifo_ctrl_occ
  import fifo_ctrl_pkg::*;
#(
  parameter int CntWidth = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Inc,
  input  logic                Dec,
  output logic [CntWidth-1:0] Count
);

  logic [CntWidth-1:0] count_q, count_d;

  // Next count from the push/pop pair.
  always_comb begin
    count_d = count_q;
    unique case ({Inc, Dec})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign Count = count_q;

endmodule

// File: rtl/fifo_buffer_ctrl.sv
// Sequencer/arbiter for the dual-read MAC FIFO: one write port fed from a
// valid/ready stream, two read heads (P = first pass, M = second pass).
// M may only read words that P has already popped, judged on registered
// occupancy counts with no same-cycle bypass.
// Optional feature: define FIFO_CTRL_STALL_CNT_EN to add the StallCnt output.
module fifo_buffer_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DataWidth   = 32,
  parameter int BufferWidth = 2,
  parameter int BufferSize  = 2**BufferWidth,
  parameter int LenWidth    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Start,
  input  logic [LenWidth-1:0]  TileLen,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [DataWidth-1:0] InData,
  output logic                 Push,
  output logic [DataWidth-1:0] DataIn,
  input  logic                 ReqP,
  input  logic                 ReqM,
  output logic                 Pop1,
  output logic                 Pop2,
  output logic                 Busy,
  output logic                 Done
`ifdef FIFO_CTRL_STALL_CNT_EN
  ,output logic [STALL_CNT_W-1:0] StallCnt
`endif
);

  localparam int              OccW    = BufferWidth + 1;
  localparam logic [OccW-1:0] OccFull = OccW'(BufferSize);

  ctrl_state_t         state_q, state_d;
  logic [LenWidth-1:0] len_q, len_d;
  logic [LenWidth-1:0] push_cnt_q, push_cnt_d;
  logic [LenWidth-1:0] popm_cnt_q, popm_cnt_d;
  logic [OccW-1:0]     occ_p, occ_m;
  logic                active;
  logic                start_acc;

  assign active    = (state_q == RUN) || (state_q == DRAIN);
  assign start_acc = (state_q == IDLE) && Start;

  // A pop in the same cycle never frees a slot, and a push in the same cycle
  // never makes a word poppable: all decisions use registered counts.
  assign InReady = (state_q == RUN) && (occ_m < OccFull) && (push_cnt_q < len_q);
  assign Push    = InValid && InReady;
  assign DataIn  = InData;
  assign Pop1    = ReqP && (occ_p != '0) && active;
  assign Pop2    = ReqM && (occ_m > occ_p) && (popm_cnt_q < len_q) && active;
  assign Busy    = (state_q != IDLE);
  assign Done    = (state_q == DONE);

  // Tile sequencing and word counters.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    push_cnt_d = push_cnt_q;
    popm_cnt_d = popm_cnt_q;
    if (Push) push_cnt_d = push_cnt_q + LenWidth'(1);
    if (Pop2) popm_cnt_d = popm_cnt_q + LenWidth'(1);
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          len_d      = TileLen;
          push_cnt_d = '0;
          popm_cnt_d = '0;
          state_d    = (TileLen == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (Push && (push_cnt_q == len_q - LenWidth'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (Pop2 && (popm_cnt_q == len_q - LenWidth'(1))) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      push_cnt_q <= '0;
      popm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      push_cnt_q <= push_cnt_d;
      popm_cnt_q <= popm_cnt_d;
    end
  end

  fifo_ctrl_occ #(.CntWidth(OccW)) OccP (
    .clk   (clk),
    .rst   (rst),
    .Inc   (Push),
    .Dec   (Pop1),
    .Count (occ_p)
  );

  fifo_ctrl_occ #(.CntWidth(OccW)) OccM (
    .clk   (clk),
    .rst   (rst),
    .Inc   (Push),
    .Dec   (Pop2),
    .Count (occ_m)
  );

`ifdef FIFO_CTRL_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  // Saturating count of cycles where a consumer asked and was not granted.
  always_comb begin
    stall_d = stall_q;
    if (start_acc)
      stall_d = '0;
    else if (((ReqP && !Pop1) || (ReqM && !Pop2)) && (stall_q != '1))
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign StallCnt = stall_q;
`else
  // Default build: no stall statistics are kept.
`endif

endmodule

// File: tb/tb_fifo_buffer_ctrl.sv
// Self-checking bench for fifo_buffer_ctrl: a cycle model of the controller
// plus a data scoreboard of upstream words expected on DataIn.
module tb_fifo_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst, Start, InValid, InReady, Push, ReqP, ReqM, Pop1, Pop2, Busy, Done;
  logic [7:0]  TileLen;
  logic [31:0] InData, DataIn;
`ifdef FIFO_CTRL_STALL_CNT_EN
  logic [15:0] StallCnt;
`endif

  always #5 clk = ~clk;

  fifo_buffer_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .Start    (Start),
    .TileLen  (TileLen),
    .InValid  (InValid),
    .InReady  (InReady),
    .InData   (InData),
    .Push     (Push),
    .DataIn   (DataIn),
    .ReqP     (ReqP),
    .ReqM     (ReqM),
    .Pop1     (Pop1),
    .Pop2     (Pop2),
    .Busy     (Busy),
    .Done     (Done)
`ifdef FIFO_CTRL_STALL_CNT_EN
   ,.StallCnt (StallCnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] sbq[$];
  bit          pending = 0;

  // model: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
  int ms = 0, mlen = 0, mpc = 0, mmc = 0, mop = 0, mom = 0, mstall = 0;
  int t_push = 0, t_p1 = 0, t_p2 = 0, cyc = 0, last_p2 = 0, done_cyc = 0;
  bit saw_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic st, input logic [7:0] tl,
                       input logic iv, input logic rp, input logic rm);
    bit e_rdy, e_push, e_p1, e_p2, act;
    @(negedge clk);
    rst = r; Start = st; TileLen = tl; InValid = iv; ReqP = rp; ReqM = rm;
    if (iv && !pending) begin
      InData = $urandom;
      sbq.push_back(InData);
      pending = 1;
    end
    #1;
    act    = (ms == 1) || (ms == 2);
    e_rdy  = (ms == 1) && (mom < 4) && (mpc < mlen);
    e_push = iv && e_rdy;
    e_p1   = rp && (mop > 0) && act;
    e_p2   = rm && (mom > mop) && (mmc < mlen) && act;
    chk("InReady", InReady, e_rdy);
    chk("Push", Push, e_push);
    chk("Pop1", Pop1, e_p1);
    chk("Pop2", Pop2, e_p2);
    chk("Busy", Busy, ms != 0);
    chk("Done", Done, ms == 3);
`ifdef FIFO_CTRL_STALL_CNT_EN
    chk("StallCnt", StallCnt, mstall);
`endif
    if (Push) begin
      if (sbq.size() > 0) chk("DataIn", DataIn, sbq.pop_front());
      else                chk("sb_depth", sbq.size(), 1);
      pending = 0;
    end
    cyc++;
    if (Push) t_push++;
    if (Pop1) t_p1++;
    if (Pop2) begin t_p2++; last_p2 = cyc; end
    if (Done) begin saw_done = 1; done_cyc = cyc; end
    // model state update for the coming edge
    if (r) mstall = 0;
    else if (ms == 0 && st) mstall = 0;
    else if (((rp && !e_p1) || (rm && !e_p2)) && mstall < 65535) mstall++;
    if (r) begin
      ms = 0; mlen = 0; mpc = 0; mmc = 0; mop = 0; mom = 0;
    end else begin
      mop += int'(e_push) - int'(e_p1);
      mom += int'(e_push) - int'(e_p2);
      case (ms)
        0: if (st) begin
             mlen = tl; mpc = 0; mmc = 0;
             ms = (tl == 0) ? 3 : 1;
           end
        1: begin
             if (e_push) mpc++;
             if (e_p2) mmc++;
             if (e_push && mpc == mlen) ms = 2;
           end
        2: begin
             if (e_p2) mmc++;
             if (e_p2 && mmc == mlen) ms = 3;
           end
        default: ms = 0;
      endcase
    end
  endtask

  task automatic start_tile(input logic [7:0] len);
    t_push = 0; t_p1 = 0; t_p2 = 0; saw_done = 0;
    cycle(0, 1, len, 0, 0, 0);
  endtask

  task automatic run_tile(input int bound, input logic iv, input logic rp, input logic rm);
    for (int i = 0; i < bound && !saw_done; i++) cycle(0, 0, 0, iv, rp, rm);
    chk("tile_done", saw_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; Start = 0; TileLen = 0; InValid = 0; InData = 0; ReqP = 0; ReqM = 0;
    repeat (2) @(posedge clk);

    // reset state, requests held high
    cycle(1, 0, 0, 1, 1, 1);
    cycle(1, 0, 0, 1, 1, 1);

    // zero-length tile
    t_push = 0; t_p1 = 0; t_p2 = 0; saw_done = 0;
    cycle(0, 1, 0, 1, 1, 1);
    cycle(0, 0, 0, 1, 1, 1);
    chk("t1_busy", Busy, 1);
    chk("t1_done", Done, 1);
    cycle(0, 0, 0, 1, 1, 1);
    chk("t1_busy_off", Busy, 0);
    chk("t1_done_off", Done, 0);
    chk("t1_push", t_push, 0);
    chk("t1_pop1", t_p1, 0);
    chk("t1_pop2", t_p2, 0);

    // fill to full with no consumers, then free one slot via P then M
    start_tile(6);
    repeat (10) cycle(0, 0, 0, 1, 0, 0);
    chk("t2_push4", t_push, 4);
    chk("t2_full_rdy", InReady, 0);
    cycle(0, 0, 0, 1, 1, 0);
    chk("t2_pop1", Pop1, 1);
    cycle(0, 0, 0, 1, 0, 1);
    chk("t2_pop2", Pop2, 1);
    chk("t2_rdy_pop2_same", InReady, 0);
    cycle(0, 0, 0, 1, 0, 0);
    chk("t2_push_next", Push, 1);
    chk("t2_push5", t_push, 5);
    run_tile(100, 1, 1, 1);
    chk("t2_push_total", t_push, 6);
    chk("t2_pop2_total", t_p2, 6);

    // streaming tile of 8
    start_tile(8);
    run_tile(100, 1, 1, 1);
    chk("t3_push", t_push, 8);
    chk("t3_pop1", t_p1, 8);
    chk("t3_pop2", t_p2, 8);
    chk("t3_done_lat", done_cyc - last_p2, 1);

    // empty FIFO: same-cycle push does not enable Pop1
    start_tile(2);
    cycle(0, 0, 0, 1, 1, 0);
    chk("t4_push", Push, 1);
    chk("t4_pop1_blocked", Pop1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("t4_pop1_next", Pop1, 1);
    run_tile(100, 1, 1, 1);

    // reset in the middle of a tile
    start_tile(5);
    for (int i = 0; i < 20 && t_push < 3; i++) cycle(0, 0, 0, 1, 0, 0);
    chk("t5_push3", t_push, 3);
    cycle(1, 0, 0, 1, 1, 1);
    cycle(0, 0, 0, 1, 1, 1);
    chk("t5_busy", Busy, 0);
    chk("t5_rdy", InReady, 0);
    chk("t5_no_done", saw_done, 0);
    start_tile(2);
    run_tile(100, 1, 1, 1);
    chk("t5_push2", t_push, 2);
    chk("t5_pop2", t_p2, 2);

`ifdef FIFO_CTRL_STALL_CNT_EN
    // M starved while OccM == OccP
    start_tile(3);
    repeat (5) cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t6_stall5", StallCnt, 5);
    run_tile(100, 1, 1, 1);
    start_tile(3);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t6_stall_clr", StallCnt, 0);
    run_tile(100, 1, 1, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
